// File: rtl/bcrypt_stream_downsizer.sv
// Width downsizer for the bcrypt output path: DEPTH-word input FIFO feeding an IN_W->OUT_W AXIS serialiser.
// Define BCRYPT_DWN_PKTCNT_EN to build the completed-packet counter on pkt_count.
module bcrypt_stream_downsizer #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic [IN_W-1:0]            s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       s_last,
  input  logic                       flush,
  output logic [OUT_W-1:0]           m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy,
  output logic [15:0]                pkt_count
);

  // state | meaning
  // IDLE  | no word in the serialiser, waiting for the FIFO to go non-empty
  // EMIT  | shreg holds a word, presenting beat beat_cnt on the AXIS port

  localparam int RATIO = IN_W / OUT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);

  if ((IN_W % OUT_W) != 0 || IN_W < OUT_W) begin : g_bad_width
    $error("bcrypt_stream_downsizer: IN_W must be an integer multiple of OUT_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("bcrypt_stream_downsizer: DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  logic [IN_W:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level, level_nx;
  logic            s_ready_q;
  logic            push, pop, empty;
  state_t          state, state_nx;
  logic [CW-1:0]   beat_cnt, beat_cnt_nx;
  logic [CW-1:0]   slice_sel;
  logic [IN_W-1:0] shreg;
  logic            last_reg;

  assign empty   = (level == '0);
  // registered readiness keeps s_ready free of any path from m_tready
  assign s_ready = s_ready_q & ~flush;
  assign push    = s_valid & s_ready;

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          beat_cnt_nx = '0;
          state_nx    = EMIT;
        end
      end
      EMIT: begin
        if (m_tready) begin
          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nx = '0;
            if (!empty) pop = 1'b1;
            else        state_nx = IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx    = IDLE;
      beat_cnt_nx = '0;
      pop         = 1'b0;
    end
  end

  always_comb begin
    level_nx = level;
    if (flush)            level_nx = '0;
    else if (push && !pop) level_nx = level + 1'b1;
    else if (!push && pop) level_nx = level - 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      level     <= level_nx;
      s_ready_q <= (level_nx != FULL_LVL);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      beat_cnt <= '0;
      shreg    <= '0;
      last_reg <= 1'b0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      if (flush)    last_reg <= 1'b0;
      else if (pop) {last_reg, shreg} <= mem[rd_ptr];
    end
  end

  always_comb begin
    slice_sel = (LSB_FIRST != 0) ? beat_cnt : (LAST_BEAT - beat_cnt);
    m_tdata   = shreg[slice_sel*OUT_W +: OUT_W];
  end

  assign m_tvalid   = (state == EMIT);
  assign m_tlast    = m_tvalid & last_reg & (beat_cnt == LAST_BEAT);
  assign fifo_level = level;
  assign busy       = (level != '0) | m_tvalid;

`ifdef BCRYPT_DWN_PKTCNT_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                              pkt_cnt_q <= 16'd0;
    else if (m_tvalid && m_tready && m_tlast) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign pkt_count = pkt_cnt_q;
`else
  assign pkt_count = 16'd0;
`endif

endmodule

// File: tb/tb_bcrypt_stream_downsizer.sv
// Bench for bcrypt_stream_downsizer: a 16->8 LSB-first and a 32->8 MSB-first instance,
// checked against a beat-queue model built from every accepted word.
module tb_bcrypt_stream_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] s_data [2];
  logic        s_valid [2];
  logic        s_last [2];
  logic        flush [2];
  logic        m_tready [2];
  logic        s_ready [2];
  logic        m_tvalid [2];
  logic        m_tlast [2];
  logic        busy [2];
  logic [7:0]  m_tdata [2];
  logic [2:0]  fifo_level [2];
  logic [15:0] pkt_count [2];
  bit          rnd_rdy [2];

  int n_cmp = 0;
  int n_mis = 0;

  bcrypt_stream_downsizer #(.IN_W(16), .OUT_W(8), .DEPTH(4), .LSB_FIRST(1)) u_dut16 (
    .CLK(clk), .RSTN(rst_n),
    .s_data(s_data[0][15:0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_last(s_last[0]),
    .flush(flush[0]),
    .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tlast(m_tlast[0]),
    .fifo_level(fifo_level[0]), .busy(busy[0]), .pkt_count(pkt_count[0])
  );

  bcrypt_stream_downsizer #(.IN_W(32), .OUT_W(8), .DEPTH(4), .LSB_FIRST(0)) u_dut32 (
    .CLK(clk), .RSTN(rst_n),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_last(s_last[1]),
    .flush(flush[1]),
    .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tlast(m_tlast[1]),
    .fifo_level(fifo_level[1]), .busy(busy[1]), .pkt_count(pkt_count[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(int n);
`ifdef BCRYPT_DWN_PKTCNT_EN
    return 32'(n & 32'hFFFF);
`else
    return 32'(n & 0);
`endif
  endfunction

  // Reference model: each accepted word expands into RATIO {last, byte} entries.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int R   = (g == 0) ? 2 : 4;
    localparam bit LSB = (g == 0);
    logic [8:0] q[$];
    int exp_pkt = 0;

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
        exp_pkt = 0;
      end else begin
        chk($sformatf("pkt_count%0d", g), 32'(pkt_count[g]), exp_cnt(exp_pkt));
        if (flush[g]) begin
          if (m_tvalid[g] && m_tready[g] && q.size() != 0 && q[0][8]) exp_pkt++;
          q.delete();
        end else begin
          if (m_tvalid[g]) begin
            if (q.size() == 0) begin
              chk($sformatf("unexpected_beat%0d", g), 32'(m_tvalid[g]), 32'd0);
            end else begin
              chk($sformatf("tdata%0d", g), 32'(m_tdata[g]), 32'(q[0][7:0]));
              chk($sformatf("tlast%0d", g), 32'(m_tlast[g]), 32'(q[0][8]));
              if (m_tready[g]) begin
                if (q[0][8]) exp_pkt++;
                void'(q.pop_front());
              end
            end
          end
          if (s_valid[g] && s_ready[g]) begin
            for (int k = 0; k < R; k++)
              q.push_back({1'(s_last[g] && k == R - 1),
                           8'(s_data[g] >> (8 * (LSB ? k : R - 1 - k)))});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (rnd_rdy[i]) m_tready[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic push(int g, logic [31:0] d, logic l);
    bit ok = 1'b0;
    s_data[g]  = d;
    s_last[g]  = l;
    s_valid[g] = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = s_ready[g];
      step();
    end
    chk($sformatf("push_accept%0d", g), 32'(ok), 32'd1);
  endtask

  task automatic idle(int g);
    s_valid[g] = 1'b0;
    s_last[g]  = 1'b0;
  endtask

  task automatic drain(int g);
    bit done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = !busy[g] && !m_tvalid[g];
      step();
    end
    chk($sformatf("drain%0d", g), 32'(done), 32'd1);
  endtask

  initial begin
    logic [7:0]  exp4 [4];
    logic [15:0] w [6];
    logic [31:0] wa, wb, d0, sample;
    int          npk [2];
    int          g;

    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data[i] = '0; s_valid[i] = 1'b0; s_last[i] = 1'b0;
      flush[i] = 1'b0; m_tready[i] = 1'b1; rnd_rdy[i] = 1'b0;
      npk[i] = 0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_tvalid", 32'(m_tvalid[i]), 32'd0);
      chk("rst_tlast",  32'(m_tlast[i]),  32'd0);
      chk("rst_tdata",  32'(m_tdata[i]),  32'd0);
      chk("rst_sready", 32'(s_ready[i]),  32'd0);
      chk("rst_level",  32'(fifo_level[i]), 32'd0);
      chk("rst_busy",   32'(busy[i]),     32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_sready_low", 32'(s_ready[0]), 32'd0);
    step();
    @(negedge clk);
    chk("rel_sready_high", 32'(s_ready[0]), 32'd1);
    step();

    // T1: single word, two beats, tlast on the high byte
    push(0, 32'h0000BEEF, 1'b1); idle(0); npk[0]++;
    @(negedge clk);
    chk("t1_busy_fifo", 32'(busy[0]), 32'd1);
    chk("t1_lat_tvalid", 32'(m_tvalid[0]), 32'd0);
    step(); @(negedge clk);
    chk("t1_b0_tvalid", 32'(m_tvalid[0]), 32'd1);
    chk("t1_b0_data", 32'(m_tdata[0]), 32'hEF);
    chk("t1_b0_last", 32'(m_tlast[0]), 32'd0);
    step(); @(negedge clk);
    chk("t1_b1_data", 32'(m_tdata[0]), 32'hBE);
    chk("t1_b1_last", 32'(m_tlast[0]), 32'd1);
    step(); @(negedge clk);
    chk("t1_end_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("t1_end_busy", 32'(busy[0]), 32'd0);
    step();

    // T2: four back-to-back words; beats 02..07 on consecutive cycles proves no bubble
    push(0, 32'h0100, 1'b0);
    push(0, 32'h0302, 1'b0);
    push(0, 32'h0504, 1'b0);
    push(0, 32'h0706, 1'b1); idle(0); npk[0]++;
    for (int k = 2; k < 8; k++) begin
      @(negedge clk);
      chk("t2_tvalid", 32'(m_tvalid[0]), 32'd1);
      chk("t2_data", 32'(m_tdata[0]), 32'(k));
      chk("t2_last", 32'(m_tlast[0]), 32'(k == 7));
      step();
    end
    @(negedge clk);
    chk("t2_end_tvalid", 32'(m_tvalid[0]), 32'd0);
    step();

    // T3: stalled sink, FIFO fills to DEPTH with one word in the serialiser
    m_tready[0] = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 5; i++) push(0, 32'(w[i]), 1'b0);
    s_data[0] = 32'(w[5]); s_last[0] = 1'b1; s_valid[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_sready", 32'(s_ready[0]), 32'd0);
      chk("t3_level", 32'(fifo_level[0]), 32'd4);
      chk("t3_hold_data", 32'(m_tdata[0]), 32'(w[0][7:0]));
      step();
    end
    m_tready[0] = 1'b1;
    push(0, 32'(w[5]), 1'b1); idle(0); npk[0]++;
    drain(0);
    chk("t3_q_empty", 32'(g_mon[0].q.size()), 32'd0);

    // T4: 32->8 MSB-first
    push(1, 32'h11223344, 1'b1); idle(1);
    @(negedge clk); step();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_data", 32'(m_tdata[1]), 32'(exp4[k]));
      chk("t4_last", 32'(m_tlast[1]), 32'(k == 3));
      step();
    end
    drain(1);

    // T5a: flush after the first beat of a two-word packet
    wa = $urandom; wb = $urandom;
    push(0, wa, 1'b0); push(0, wb, 1'b1); idle(0);
    @(negedge clk);
    chk("t5f_b0_tvalid", 32'(m_tvalid[0]), 32'd1);
    chk("t5f_b0_data", 32'(m_tdata[0]), 32'(wa[7:0]));
    step();
    flush[0] = 1'b1;
    @(negedge clk);
    chk("t5f_sready", 32'(s_ready[0]), 32'd0);
    step();
    flush[0] = 1'b0;
    @(negedge clk);
    chk("t5f_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("t5f_tlast", 32'(m_tlast[0]), 32'd0);
    chk("t5f_level", 32'(fifo_level[0]), 32'd0);
    chk("t5f_busy", 32'(busy[0]), 32'd0);
    step();
    push(0, $urandom, 1'b1); idle(0); npk[0]++;
    drain(0);
    chk("t5f_q_empty", 32'(g_mon[0].q.size()), 32'd0);

    // T5b: same cut with a reset pulse instead of flush
    wa = $urandom; wb = $urandom;
    push(0, wa, 1'b0); push(0, wb, 1'b1); idle(0);
    @(negedge clk);
    chk("t5r_b0_data", 32'(m_tdata[0]), 32'(wa[7:0]));
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5r_tvalid", 32'(m_tvalid[0]), 32'd0);
    chk("t5r_level", 32'(fifo_level[0]), 32'd0);
    chk("t5r_busy", 32'(busy[0]), 32'd0);
    step();
    rst_n = 1'b1;
    npk[0] = 0; npk[1] = 0;
    @(negedge clk);
    chk("t5r_sready_low", 32'(s_ready[0]), 32'd0);
    step(); @(negedge clk);
    chk("t5r_sready_high", 32'(s_ready[0]), 32'd1);
    step();
    push(0, $urandom, 1'b1); idle(0); npk[0]++;
    drain(0);

    // T6: packet counter, one packet stalled by the sink
    push(0, $urandom, 1'b1); idle(0); npk[0]++;
    m_tready[0] = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t6_stall_tvalid", 32'(m_tvalid[0]), 32'd1);
    step();
    m_tready[0] = 1'b1;
    drain(0);
    push(0, $urandom, 1'b0); push(0, $urandom, 1'b1); idle(0); npk[0]++;
    drain(0);
    chk("t6_pkt_count", 32'(pkt_count[0]), exp_cnt(3));

    // Randomised traffic with random sink backpressure on both instances
    rnd_rdy[0] = 1'b1; rnd_rdy[1] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      g  = $urandom_range(0, 1);
      d0 = $urandom;
      sample = 32'($urandom_range(0, 3) == 0);
      push(g, d0, sample[0]); idle(g);
      if (sample[0]) npk[g]++;
      if ($urandom_range(0, 2) == 0) step();
    end
    for (int i = 0; i < 2; i++) begin
      push(i, $urandom, 1'b1); idle(i); npk[i]++;
    end
    rnd_rdy[0] = 1'b0; rnd_rdy[1] = 1'b0;
    m_tready[0] = 1'b1; m_tready[1] = 1'b1;
    drain(0); drain(1);
    chk("rnd_pkt0", 32'(pkt_count[0]), exp_cnt(npk[0]));
    chk("rnd_pkt1", 32'(pkt_count[1]), exp_cnt(npk[1]));
    chk("rnd_q0_empty", 32'(g_mon[0].q.size()), 32'd0);
    chk("rnd_q1_empty", 32'(g_mon[1].q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
